// File: rtl/uart_led_pkg.sv
// uart_led_pkg: ASCII constants, colour enum and state encoding shared by
// the UART LED command parser and its helpers.
package uart_led_pkg;

    localparam logic [7:0] CHAR_R  = 8'h72;
    localparam logic [7:0] CHAR_G  = 8'h67;
    localparam logic [7:0] CHAR_B  = 8'h62;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_QM = 8'h3F;
    localparam logic [7:0] CHAR_K  = 8'h4B;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } colour_e;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LED   = 3'd1;
    localparam logic [2:0] ST_HEXHI = 3'd2;
    localparam logic [2:0] ST_HEXLO = 3'd3;
    localparam logic [2:0] ST_NL    = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;

endpackage

// File: rtl/ascii_hex_decode.sv
// ascii_hex_decode: maps an ASCII hex digit (0-9, a-f, A-F) to its nibble
// value and flags whether the byte was a hex digit at all.
module ascii_hex_decode (
    input  logic [7:0] i_Char,
    output logic [3:0] o_Nibble,
    output logic       o_Valid
);

    always_comb begin
        o_Nibble = 4'd0;
        o_Valid  = 1'b1;
        unique case (1'b1)
            (i_Char >= 8'h30 && i_Char <= 8'h39): o_Nibble = i_Char[3:0];
            (i_Char >= 8'h61 && i_Char <= 8'h66): o_Nibble = i_Char[3:0] + 4'd9;
            (i_Char >= 8'h41 && i_Char <= 8'h46): o_Nibble = i_Char[3:0] + 4'd9;
            default:                              o_Valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_led_cmd_parser.sv
// uart_led_cmd_parser: echoes RX bytes to TX and parses "<c><n>[hh]\n" LED commands.
// Define UART_LED_CMD_ERROR_REPLY_EN to reply '?' on errors and 'K' after good commands.
module uart_led_cmd_parser #(
    parameter int unsigned CLOCK_FREQUENCY = 80000000,
    parameter int unsigned TIMEOUT_MS      = 100,
    parameter logic [7:0]  TOGGLE_LEVEL    = 8'h11
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Data_Ready,
    input  logic [7:0] i_Data,
    output logic       o_Read_Data,
    input  logic       i_Busy_TX,
    output logic       o_Start,
    output logic [7:0] o_TX_Data,
    output logic [7:0] o_LED1_R,
    output logic [7:0] o_LED1_G,
    output logic [7:0] o_LED1_B,
    output logic [7:0] o_LED2_R,
    output logic [7:0] o_LED2_G,
    output logic [7:0] o_LED2_B,
    output logic [7:0] o_LED3_R,
    output logic [7:0] o_LED3_G,
    output logic [7:0] o_LED3_B,
    output logic       o_Update,
    output logic [7:0] o_Error_Count
);
    import uart_led_pkg::*;

    localparam int unsigned TO_CYCLES = CLOCK_FREQUENCY / 1000 * TIMEOUT_MS;
    localparam int TO_W = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES);

    logic [2:0]      r_State;
    logic [2:0]      w_Next;
    colour_e         r_Colour;
    colour_e         w_Colour;
    logic [3:0]      r_Target;
    logic [3:0]      r_Hi;
    logic [3:0]      r_Lo;
    logic [7:0]      r_Led [0:8];
    logic [TO_W-1:0] r_Timer;

    logic       w_Accept;
    logic       w_Active;
    logic       w_Stall;
    logic       w_Timeout;
    logic       w_Err;
    logic       w_Err_Inc;
    logic       w_Commit;
    logic       w_Is_Colour;
    logic       w_Is_Index;
    logic       w_Is_LF;
    logic       w_Hex_Valid;
    logic [3:0] w_Nibble;
    logic [1:0] w_Idx;
    logic [7:0] w_Toggle_Val;
    logic [7:0] w_Write_Val;

    ascii_hex_decode u_hex (
        .i_Char   (i_Data),
        .o_Nibble (w_Nibble),
        .o_Valid  (w_Hex_Valid)
    );

`ifdef UART_LED_CMD_ERROR_REPLY_EN
    logic r_K_Pend;
    assign w_Stall = r_K_Pend;
`else
    assign w_Stall = 1'b0;
`endif

    // Pulses block the following cycle, covering the FIFO and TX flag lag.
    assign w_Accept = i_Data_Ready & ~i_Busy_TX & ~o_Read_Data & ~o_Start & ~w_Stall;
    assign w_Active = w_Accept && (i_Data != CHAR_CR);
    assign w_Is_LF  = (i_Data == CHAR_LF);
    assign w_Is_Index = (i_Data == 8'h31) || (i_Data == 8'h32) || (i_Data == 8'h33);
    assign w_Idx    = i_Data[1:0] - 2'd1;
    assign w_Timeout = (TIMEOUT_MS != 0) && !w_Accept && (r_Timer == TO_LAST);
    assign w_Err_Inc = (w_Active && w_Err)
                     || (w_Timeout && r_State != ST_DRAIN);

    assign w_Toggle_Val = (r_Led[r_Target] == 8'd0) ? TOGGLE_LEVEL : 8'd0;
    assign w_Write_Val  = (r_State == ST_HEXHI) ? w_Toggle_Val : {r_Hi, r_Lo};

    always_comb begin
        w_Is_Colour = 1'b1;
        w_Colour    = RED;
        unique case (1'b1)
            (i_Data == CHAR_R): w_Colour = RED;
            (i_Data == CHAR_G): w_Colour = GREEN;
            (i_Data == CHAR_B): w_Colour = BLUE;
            default:            w_Is_Colour = 1'b0;
        endcase
    end

    always_comb begin
        w_Next   = r_State;
        w_Err    = 1'b0;
        w_Commit = 1'b0;
        unique case (r_State)
            ST_IDLE: begin
                if (w_Is_Colour) w_Next = ST_LED;
                else if (!w_Is_LF) begin w_Next = ST_DRAIN; w_Err = 1'b1; end
            end
            ST_LED: begin
                if (w_Is_Index) w_Next = ST_HEXHI;
                else begin w_Err = 1'b1; w_Next = w_Is_LF ? ST_IDLE : ST_DRAIN; end
            end
            ST_HEXHI: begin
                if (w_Is_LF) begin w_Commit = 1'b1; w_Next = ST_IDLE; end
                else if (w_Hex_Valid) w_Next = ST_HEXLO;
                else begin w_Err = 1'b1; w_Next = ST_DRAIN; end
            end
            ST_HEXLO: begin
                if (w_Hex_Valid) w_Next = ST_NL;
                else begin w_Err = 1'b1; w_Next = w_Is_LF ? ST_IDLE : ST_DRAIN; end
            end
            ST_NL: begin
                if (w_Is_LF) begin w_Commit = 1'b1; w_Next = ST_IDLE; end
                else begin w_Err = 1'b1; w_Next = ST_DRAIN; end
            end
            ST_DRAIN: if (w_Is_LF) w_Next = ST_IDLE;
            default:  w_Next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State       <= ST_IDLE;
            r_Colour      <= RED;
            r_Target      <= '0;
            r_Hi          <= '0;
            r_Lo          <= '0;
            r_Timer       <= '0;
            o_Read_Data   <= 1'b0;
            o_Start       <= 1'b0;
            o_TX_Data     <= '0;
            o_Update      <= 1'b0;
            o_Error_Count <= '0;
            for (int k = 0; k < 9; k++) r_Led[k] <= '0;
`ifdef UART_LED_CMD_ERROR_REPLY_EN
            r_K_Pend      <= 1'b0;
`endif
        end else begin
            o_Read_Data <= w_Accept;
            o_Start     <= w_Accept;
            o_Update    <= w_Active && w_Commit;
`ifdef UART_LED_CMD_ERROR_REPLY_EN
            if (w_Accept) o_TX_Data <= (w_Active && w_Err) ? CHAR_QM : i_Data;
            if (w_Active && w_Commit) r_K_Pend <= 1'b1;
            else if (r_K_Pend && !i_Busy_TX && !o_Start) begin
                o_Start   <= 1'b1;
                o_TX_Data <= CHAR_K;
                r_K_Pend  <= 1'b0;
            end
`else
            if (w_Accept) o_TX_Data <= i_Data;
`endif
            if (w_Accept || w_Timeout || r_State == ST_IDLE) r_Timer <= '0;
            else r_Timer <= r_Timer + 1'b1;

            if (w_Active) r_State <= w_Next;
            else if (w_Timeout) r_State <= ST_IDLE;

            if (w_Active && r_State == ST_IDLE) r_Colour <= w_Colour;
            if (w_Active && r_State == ST_LED)
                r_Target <= 4'(w_Idx) * 4'd3 + 4'(r_Colour);
            if (w_Active && r_State == ST_HEXHI) r_Hi <= w_Nibble;
            if (w_Active && r_State == ST_HEXLO) r_Lo <= w_Nibble;
            if (w_Active && w_Commit) r_Led[r_Target] <= w_Write_Val;

            if (w_Err_Inc && o_Error_Count != 8'hFF)
                o_Error_Count <= o_Error_Count + 8'd1;
        end
    end

    assign o_LED1_R = r_Led[0];
    assign o_LED1_G = r_Led[1];
    assign o_LED1_B = r_Led[2];
    assign o_LED2_R = r_Led[3];
    assign o_LED2_G = r_Led[4];
    assign o_LED2_B = r_Led[5];
    assign o_LED3_R = r_Led[6];
    assign o_LED3_G = r_Led[7];
    assign o_LED3_B = r_Led[8];

endmodule

// File: doc/uart_led_cmd_parser.md
Name: uart_led_cmd_parser

Overview:
- Consumes bytes from the UART RX FIFO and echoes each accepted byte to the UART TX.
- Parses ASCII LED commands and holds nine 8-bit colour registers (3 LEDs x R/G/B) that feed the WS2812 driver directly.
- Sits between the UART module and the WS2812 module, replacing the ad-hoc command state machine in the top level.
- Grammar: `<colour><led>[<hexhi><hexlo>]\n`. Toggle form example: "r1\n". Set form example: "g2A0\n".

Parameters:
- CLOCK_FREQUENCY, 80000000, system clock in Hz; used only to derive the timeout.
- TIMEOUT_MS, 100, idle time allowed inside a partial command before it is abandoned; 0 disables the timeout.
- TOGGLE_LEVEL, 8'h11, value written by the toggle form when the target register is zero.

Ports:
- i_Clock  in  1  system clock; all state changes on the rising edge.
- i_Reset  in  1  reset, asynchronous, active-high.
- i_Data_Ready  in  1  RX FIFO not empty.
- i_Data  in  8  RX FIFO head byte; valid while i_Data_Ready=1.
- o_Read_Data  out  1  one-cycle pop pulse to the RX FIFO.
- i_Busy_TX  in  1  UART transmitter busy.
- o_Start  out  1  one-cycle TX start pulse.
- o_TX_Data  out  8  byte to transmit; stable from the o_Start cycle until the next accept.
- o_LED1_R, o_LED1_G, o_LED1_B, o_LED2_R, o_LED2_G, o_LED2_B, o_LED3_R, o_LED3_G, o_LED3_B  out  8 each  colour registers.
- o_Update  out  1  one-cycle pulse, asserted the cycle after any colour register changes value or is written.
- o_Error_Count  out  8  count of malformed or timed-out commands; saturates at 255.

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0.
- Accept condition: i_Data_Ready & ~i_Busy_TX & ~o_Read_Data & ~o_Start. This allows at most one accept per two cycles and covers the one-cycle flag lag in both the FIFO and the TX.
- On accept, in the same edge: o_Read_Data<=1, o_Start<=1, o_TX_Data<=i_Data (echo); the state transition happens on that edge. Both pulses clear on the next edge.
- Byte 8'h0D ('\r') is accepted and echoed in every state, with no state change.
- States and transitions:
  - IDLE: 'r'(72)/'g'(67)/'b'(62) latch colour -> LED. 8'h0A -> IDLE, no error (empty line). Any other byte -> DRAIN + error.
  - LED: '1'..'3'(31-33) latch index 0..2 -> HEXHI. Other -> DRAIN + error, except 8'h0A -> IDLE + error.
  - HEXHI:
    - 8'h0A -> toggle target (0 -> TOGGLE_LEVEL, nonzero -> 0), pulse o_Update, -> IDLE.
    - Hex digit ('0'-'9','a'-'f','A'-'F') -> latch high nibble -> HEXLO.
    - Other -> DRAIN + error.
  - HEXLO: hex digit -> latch low nibble -> NL. Other -> DRAIN + error (8'h0A -> IDLE + error).
  - NL: 8'h0A -> write {hi,lo} to target, pulse o_Update, -> IDLE. Other -> DRAIN + error.
  - DRAIN: discard (still echo) until 8'h0A -> IDLE.
- Error: o_Error_Count increments by 1 per malformed command, once (on the offending byte); saturates at 255; no register is modified.
- Timeout:
  - Counter width $clog2(CLOCK_FREQUENCY/1000*TIMEOUT_MS+1).
  - Cleared on every accept and while in IDLE; increments each cycle otherwise.
  - At terminal count: state -> IDLE, error count increments. A timeout in DRAIN returns to IDLE without incrementing.
- Accept and timeout in the same cycle: the accept wins; the counter clears.
- Register write and o_Update occur only on the terminating '\n'. Partial commands never alter outputs.

Optional Feature:
- Macro: UART_LED_CMD_ERROR_REPLY_EN.
- Defined: on the byte that triggers an error, o_TX_Data<=8'h3F ('?') instead of the echo. On a successful write/toggle, the echoed '\n' is followed by a second transmission 8'h4B ('K'), issued once i_Busy_TX has deasserted; accepts stall until that 'K' is started.
- Undefined: pure echo only.

Decomposition:
- Shared package uart_led_pkg: ASCII constants (CHAR_R, CHAR_G, CHAR_B, CHAR_LF, CHAR_CR, CHAR_QM, CHAR_K), colour enum (RED=0, GREEN=1, BLUE=2), state encoding.
- One sub-module: ascii_hex_decode (combinational, 8-bit in -> 4-bit nibble + valid flag).
- Register file and state machine stay in the parser.

Test Plan:
- Feed "r1\n" from reset -> o_LED1_R=8'h11, o_Update pulses once, TX echoes 72,31,0A. Feed "r1\n" again -> o_LED1_R=8'h00.
- Feed "b3fF\n" -> o_LED3_B=8'hFF; "g2\r0a\n" -> o_LED2_G=8'h0A with the CR ignored; all other registers stay 0.
- Feed "x1\n" then "g4\n" then "r1Z\n" -> o_Error_Count=3, no register change, each command fully echoed (with macro: offending byte replaced by 3F).
- Feed "r2" and stall beyond TIMEOUT_MS (reduce the parameter to 1 us in sim) -> state returns to IDLE, o_Error_Count=1. Then "r2\n" -> o_LED2_R=8'h11.
- Hold i_Busy_TX=1 with i_Data_Ready=1 -> no o_Read_Data. On release, exactly one pop per byte, never two in adjacent cycles; FIFO never over-read.
- Assert i_Reset mid-command after "b1F" -> all outputs 0 immediately (asynchronous). Then "b1\n" -> o_LED1_B=8'h11.
